// File: rtl/ioctl_ram_sched.sv
// ioctl_ram_sched: shares one single-port RAM between the CPU bus and a FIFO-buffered ioctl download stream.
// Optional define IOCTL_SCHED_CHKSUM_EN adds dl_sum, a running 16-bit sum of download bytes committed to RAM.
module ioctl_ram_sched #(
   parameter int AW         = 25,
   parameter int FIFO_DEPTH = 4,
   parameter int MAX_STARVE = 3
) (
   input  logic          clk_sys,
   input  logic          reset,
   input  logic          ioctl_download,
   input  logic          ioctl_wr,
   input  logic [AW-1:0] ioctl_addr,
   input  logic [7:0]    ioctl_dout,
   output logic          ioctl_wait,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [7:0]    cpu_din,
   output logic [7:0]    cpu_dout,
   output logic          cpu_ack,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [7:0]    mem_din,
   input  logic [7:0]    mem_dout,
   input  logic          mem_ack,
   output logic          dl_busy,
   output logic          dl_done,
`ifdef IOCTL_SCHED_CHKSUM_EN
   output logic [15:0]   dl_sum,
`endif
   output logic          dl_ovf
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = (MAX_STARVE < 1) ? 1 : $clog2(MAX_STARVE + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CPU  = 2'd1,
      ST_DL   = 2'd2
   } state_t;

   state_t          state_r;
   state_t          state_s;

   logic [AW-1:0]   fifo_addr_r [FIFO_DEPTH];
   logic [7:0]      fifo_data_r [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr_r;
   logic [PW-1:0]   rd_ptr_r;
   logic [CW-1:0]   count_r;
   logic [CW-1:0]   count_s;

   logic            wr_d_r;
   logic            dl_d_r;
   logic            push_s;
   logic            push_ok_s;
   logic            pop_s;
   logic            fifo_full_s;
   logic            fifo_empty_s;
   logic            dl_rise_s;
   logic            dl_clear_s;
   logic [AW-1:0]   head_addr_s;
   logic [7:0]      head_data_s;

   logic [SW-1:0]   starve_r;
   logic [SW-1:0]   starve_s;

   logic            mem_req_r;
   logic            mem_req_s;
   logic            mem_we_r;
   logic            mem_we_s;
   logic [AW-1:0]   mem_addr_r;
   logic [AW-1:0]   mem_addr_s;
   logic [7:0]      mem_din_r;
   logic [7:0]      mem_din_s;
   logic            cpu_ack_r;
   logic            cpu_ack_s;
   logic [7:0]      cpu_dout_r;
   logic [7:0]      cpu_dout_s;
   logic            ioctl_wait_r;
   logic            dl_busy_r;
   logic            dl_done_r;
   logic            dl_ovf_r;

   assign push_s       = ioctl_download & ioctl_wr & ~wr_d_r;
   assign fifo_full_s  = (count_r == CW'(FIFO_DEPTH));
   assign fifo_empty_s = (count_r == {CW{1'b0}});
   assign push_ok_s    = push_s & ~fifo_full_s;
   assign pop_s        = (state_r == ST_DL) & mem_ack;
   assign head_addr_s  = fifo_addr_r[rd_ptr_r];
   assign head_data_s  = fifo_data_r[rd_ptr_r];
   assign dl_rise_s    = ioctl_download & ~dl_d_r;
   assign dl_clear_s   = ~ioctl_download & fifo_empty_s & (state_r != ST_DL);

   // FIFO occupancy after this cycle's push and pop
   always_comb begin
      count_s = count_r;
      case ({push_ok_s, pop_s})
         2'b10:   count_s = count_r + CW'(1);
         2'b01:   count_s = count_r - CW'(1);
         default: count_s = count_r;
      endcase
   end

   // FIFO storage; contents need no reset since occupancy is tracked separately
   always_ff @(posedge clk_sys) begin
      if (push_ok_s) begin
         fifo_addr_r[wr_ptr_r] <= ioctl_addr;
         fifo_data_r[wr_ptr_r] <= ioctl_dout;
      end
   end

   // FIFO pointers, strobe edge detect, throttle and overflow flag
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         wr_ptr_r     <= {PW{1'b0}};
         rd_ptr_r     <= {PW{1'b0}};
         count_r      <= {CW{1'b0}};
         wr_d_r       <= 1'b0;
         ioctl_wait_r <= 1'b0;
         dl_ovf_r     <= 1'b0;
      end else begin
         wr_d_r       <= ioctl_wr;
         count_r      <= count_s;
         ioctl_wait_r <= (count_s >= CW'(FIFO_DEPTH - 1));
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         if (push_s && fifo_full_s) begin
            dl_ovf_r <= 1'b1;
         end
      end
   end

   // Arbitration: picks the next requester and forms the registered RAM/CPU outputs
   always_comb begin
      state_s    = state_r;
      mem_req_s  = mem_req_r;
      mem_we_s   = mem_we_r;
      mem_addr_s = mem_addr_r;
      mem_din_s  = mem_din_r;
      cpu_ack_s  = 1'b0;
      cpu_dout_s = cpu_dout_r;
      starve_s   = starve_r;
      case (state_r)
         ST_IDLE: begin
            if (!fifo_empty_s && (!cpu_req || (starve_r >= SW'(MAX_STARVE)))) begin
               state_s    = ST_DL;
               mem_req_s  = 1'b1;
               mem_we_s   = 1'b1;
               mem_addr_s = head_addr_s;
               mem_din_s  = head_data_s;
            end else if (cpu_req) begin
               state_s    = ST_CPU;
               mem_req_s  = 1'b1;
               mem_we_s   = cpu_we;
               mem_addr_s = cpu_addr;
               mem_din_s  = cpu_din;
            end else begin
               mem_req_s  = 1'b0;
               mem_we_s   = 1'b0;
            end
         end
         ST_CPU: begin
            if (mem_ack) begin
               state_s   = ST_IDLE;
               mem_req_s = 1'b0;
               mem_we_s  = 1'b0;
               cpu_ack_s = 1'b1;
               if (!mem_we_r) begin
                  cpu_dout_s = mem_dout;
               end else begin
                  cpu_dout_s = cpu_dout_r;
               end
               // Only CPU grants that bypass waiting download data count as starvation
               if (!fifo_empty_s && (starve_r < SW'(MAX_STARVE))) begin
                  starve_s = starve_r + SW'(1);
               end else begin
                  starve_s = starve_r;
               end
            end else begin
               state_s = ST_CPU;
            end
         end
         ST_DL: begin
            if (mem_ack) begin
               state_s   = ST_IDLE;
               mem_req_s = 1'b0;
               mem_we_s  = 1'b0;
               starve_s  = {SW{1'b0}};
            end else begin
               state_s = ST_DL;
            end
         end
         default: begin
            state_s   = ST_IDLE;
            mem_req_s = 1'b0;
            mem_we_s  = 1'b0;
         end
      endcase
   end

   // State and registered outputs; reset abandons any in-flight RAM access
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         starve_r   <= {SW{1'b0}};
         mem_req_r  <= 1'b0;
         mem_we_r   <= 1'b0;
         mem_addr_r <= {AW{1'b0}};
         mem_din_r  <= 8'h00;
         cpu_ack_r  <= 1'b0;
         cpu_dout_r <= 8'h00;
      end else begin
         state_r    <= state_s;
         starve_r   <= starve_s;
         mem_req_r  <= mem_req_s;
         mem_we_r   <= mem_we_s;
         mem_addr_r <= mem_addr_s;
         mem_din_r  <= mem_din_s;
         cpu_ack_r  <= cpu_ack_s;
         cpu_dout_r <= cpu_dout_s;
      end
   end

   // Download lifetime: busy from the download start until the FIFO has fully drained
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         dl_d_r    <= 1'b0;
         dl_busy_r <= 1'b0;
         dl_done_r <= 1'b0;
      end else begin
         dl_d_r <= ioctl_download;
         if (dl_rise_s) begin
            dl_busy_r <= 1'b1;
            dl_done_r <= 1'b0;
         end else if (dl_busy_r && dl_clear_s) begin
            dl_busy_r <= 1'b0;
            dl_done_r <= 1'b1;
         end else begin
            dl_done_r <= 1'b0;
         end
      end
   end

`ifdef IOCTL_SCHED_CHKSUM_EN
   logic [15:0] dl_sum_r;

   // Checksum counts bytes as they land in RAM, not as they enter the FIFO
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         dl_sum_r <= 16'h0000;
      end else if (dl_rise_s) begin
         dl_sum_r <= 16'h0000;
      end else if (pop_s) begin
         dl_sum_r <= dl_sum_r + {8'h00, mem_din_r};
      end
   end

   assign dl_sum = dl_sum_r;
`endif

   assign ioctl_wait = ioctl_wait_r;
   assign cpu_dout   = cpu_dout_r;
   assign cpu_ack    = cpu_ack_r;
   assign mem_req    = mem_req_r;
   assign mem_we     = mem_we_r;
   assign mem_addr   = mem_addr_r;
   assign mem_din    = mem_din_r;
   assign dl_busy    = dl_busy_r;
   assign dl_done    = dl_done_r;
   assign dl_ovf     = dl_ovf_r;

endmodule

// File: tb/tb_ioctl_ram_sched.sv
// Scoreboard bench for ioctl_ram_sched: directed stimulus queues expected RAM accesses and CPU read data,
// a negedge monitor models the RAM (configurable ack latency) and checks everything the DUT presents.
module tb_ioctl_ram_sched;
   localparam int AW = 25;

   logic          clk_sys = 1'b0;
   logic          reset = 1'b1;
   logic          ioctl_download = 1'b0;
   logic          ioctl_wr = 1'b0;
   logic [AW-1:0] ioctl_addr = '0;
   logic [7:0]    ioctl_dout = 8'h00;
   logic          ioctl_wait;
   logic          cpu_req = 1'b0;
   logic          cpu_we = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [7:0]    cpu_din = 8'h00;
   logic [7:0]    cpu_dout;
   logic          cpu_ack;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_din;
   logic [7:0]    mem_dout = 8'h00;
   logic          mem_ack = 1'b0;
   logic          dl_busy;
   logic          dl_done;
   logic          dl_ovf;
`ifdef IOCTL_SCHED_CHKSUM_EN
   logic [15:0]   dl_sum;
`endif

   ioctl_ram_sched #(.AW(AW), .FIFO_DEPTH(4), .MAX_STARVE(3)) dut (
      .clk_sys        (clk_sys),
      .reset          (reset),
      .ioctl_download (ioctl_download),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .ioctl_wait     (ioctl_wait),
      .cpu_req        (cpu_req),
      .cpu_we         (cpu_we),
      .cpu_addr       (cpu_addr),
      .cpu_din        (cpu_din),
      .cpu_dout       (cpu_dout),
      .cpu_ack        (cpu_ack),
      .mem_req        (mem_req),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_din        (mem_din),
      .mem_dout       (mem_dout),
      .mem_ack        (mem_ack),
      .dl_busy        (dl_busy),
      .dl_done        (dl_done),
`ifdef IOCTL_SCHED_CHKSUM_EN
      .dl_sum         (dl_sum),
`endif
      .dl_ovf         (dl_ovf)
   );

   always #5 clk_sys = ~clk_sys;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int last_ack_cyc = -100;
   int cpu_acks = 0;
   int done_count = 0;
   int lat = 2;
   int req_cnt = 0;
   logic [33:0] exp_q[$];
   logic [7:0]  cpu_exp_q[$];

   task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] rd_data(input logic [AW-1:0] a);
      case (a)
         25'h0001234: return 8'h3C;
         25'h0002000: return 8'h77;
         default:     return 8'h00;
      endcase
   endfunction

   // Monitor + RAM model: all sampling of DUT outputs happens here on the falling edge
   always @(negedge clk_sys) begin
      logic [33:0] e;
      cyc++;
      if (cpu_ack === 1'b1) begin
         cpu_acks++;
         check("cpu_ack_after_mem_ack", cyc - last_ack_cyc, 1);
         if (cpu_exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL cpu_ack_unexpected: got ack with dout 0x%0h, expected no ack", cpu_dout);
         end else begin
            check("cpu_dout", cpu_dout, cpu_exp_q.pop_front());
         end
      end
      if (dl_done === 1'b1) begin
         done_count++;
         check("dl_done_after_commit", exp_q.size(), 0);
      end
      if (mem_ack) begin
         check("mem_req_drop_after_ack", mem_req, 1'b0);
         mem_ack = 1'b0;
         req_cnt = 0;
      end else if (mem_req === 1'b1) begin
         req_cnt++;
         if (req_cnt >= lat) begin
            mem_ack = 1'b1;
            last_ack_cyc = cyc;
            mem_dout = mem_we ? 8'h00 : rd_data(mem_addr);
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL mem_access_unexpected: got we=%0b addr=0x%0h din=0x%0h, expected none",
                        mem_we, mem_addr, mem_din);
            end else begin
               e = exp_q.pop_front();
               check("mem_access", {mem_we, mem_addr, mem_din}, e);
            end
         end
      end else begin
         req_cnt = 0;
      end
   end

   function automatic logic probe(input int sel);
      case (sel)
         0:       return cpu_ack;
         1:       return dl_done;
         2:       return ~ioctl_wait;
         3:       return mem_req;
         default: return 1'b0;
      endcase
   endfunction

   task automatic wait_until(input string name, input int sel, input int budget);
      int k = 0;
      while (probe(sel) !== 1'b1 && k < budget) begin
         @(negedge clk_sys);
         k++;
      end
      check(name, probe(sel), 1'b1);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk_sys);
   endtask

   task automatic strobe(input logic [AW-1:0] a, input logic [7:0] d);
      ioctl_addr = a;
      ioctl_dout = d;
      ioctl_wr   = 1'b1;
      @(negedge clk_sys);
      ioctl_wr   = 1'b0;
      @(negedge clk_sys);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int d0;
      int c0;
      int seen;
      logic [33:0] cpu_rd;

      // Reset state
      repeat (3) @(negedge clk_sys);
      check("rst_mem_req", mem_req, 1'b0);
      check("rst_mem_we", mem_we, 1'b0);
      check("rst_mem_addr", mem_addr, 25'h0);
      check("rst_cpu_ack", cpu_ack, 1'b0);
      check("rst_cpu_dout", cpu_dout, 8'h00);
      check("rst_ioctl_wait", ioctl_wait, 1'b0);
      check("rst_dl_busy", dl_busy, 1'b0);
      check("rst_dl_done", dl_done, 1'b0);
      check("rst_dl_ovf", dl_ovf, 1'b0);
      reset = 1'b0;
      @(negedge clk_sys);

      // CPU read on an idle system
      lat = 2;
      exp_q.push_back({1'b0, 25'h0001234, 8'h00});
      cpu_exp_q.push_back(8'h3C);
      check("cpu_rd_req_idle", mem_req, 1'b0);
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = 25'h0001234;
      cpu_din  = 8'h00;
      @(negedge clk_sys);
      check("cpu_rd_req_rise", mem_req, 1'b1);
      wait_until("cpu_ack_seen", 0, 50);
      cpu_req = 1'b0;
      idle(4);

      // Single download, two bytes
      d0 = done_count;
      ioctl_download = 1'b1;
      @(negedge clk_sys);
      check("dl_busy_set", dl_busy, 1'b1);
      exp_q.push_back({1'b1, 25'h0000000, 8'hA5});
      exp_q.push_back({1'b1, 25'h0000001, 8'h5A});
      strobe(25'h0000000, 8'hA5);
      strobe(25'h0000001, 8'h5A);
      ioctl_download = 1'b0;
      wait_until("dl_done_single", 1, 100);
      idle(6);
      check("dl_done_once", done_count - d0, 1);
      check("dl_busy_clear", dl_busy, 1'b0);
      check("dl_ovf_single", dl_ovf, 1'b0);
`ifdef IOCTL_SCHED_CHKSUM_EN
      check("dl_sum_single", dl_sum, 16'h00FF);
`endif

      // Backpressure with slow RAM, strobes honour ioctl_wait
      lat = 10;
      ioctl_download = 1'b1;
      @(negedge clk_sys);
      for (int k = 0; k < 8; k++) begin
         wait_until("ioctl_wait_release", 2, 200);
         exp_q.push_back({1'b1, 25'h0000100 + 25'(k), 8'h10 + 8'(k)});
         strobe(25'h0000100 + 25'(k), 8'h10 + 8'(k));
         if (k < 3) begin
            check("ioctl_wait_level", ioctl_wait, (k >= 2));
         end
      end
      ioctl_download = 1'b0;
      wait_until("dl_done_backpressure", 1, 400);
      idle(3);
      check("dl_ovf_backpressure", dl_ovf, 1'b0);
      check("backpressure_all_written", exp_q.size(), 0);

      // Overflow: six fast strobes into a four-entry FIFO
      ioctl_download = 1'b1;
      @(negedge clk_sys);
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back({1'b1, 25'h0000200 + 25'(k), 8'h80 + 8'(k)});
      end
      for (int k = 0; k < 6; k++) begin
         strobe(25'h0000200 + 25'(k), 8'h80 + 8'(k));
      end
      check("dl_ovf_set", dl_ovf, 1'b1);
      ioctl_download = 1'b0;
      wait_until("dl_done_overflow", 1, 300);
      idle(3);
      check("dl_ovf_sticky", dl_ovf, 1'b1);
      check("overflow_first4_written", exp_q.size(), 0);
`ifdef IOCTL_SCHED_CHKSUM_EN
      check("dl_sum_overflow", dl_sum, 16'h0206);
`endif

      // Starvation limit: CPU held busy while download bytes wait
      lat = 2;
      cpu_rd = {1'b0, 25'h0002000, 8'h00};
      repeat (3) exp_q.push_back(cpu_rd);
      exp_q.push_back({1'b1, 25'h0000300, 8'h11});
      repeat (3) exp_q.push_back(cpu_rd);
      exp_q.push_back({1'b1, 25'h0000301, 8'h22});
      repeat (6) cpu_exp_q.push_back(8'h77);
      c0 = cpu_acks;
      cpu_req        = 1'b1;
      cpu_we         = 1'b0;
      cpu_addr       = 25'h0002000;
      cpu_din        = 8'h00;
      ioctl_download = 1'b1;
      strobe(25'h0000300, 8'h11);
      strobe(25'h0000301, 8'h22);
      seen = 0;
      while ((cpu_acks - c0) < 6 && seen < 300) begin
         @(negedge clk_sys);
         seen++;
      end
      cpu_req = 1'b0;
      idle(10);
      check("starve_cpu_ack_count", cpu_acks - c0, 6);
      ioctl_download = 1'b0;
      wait_until("dl_done_starve", 1, 100);
      idle(3);
      check("starve_all_granted", exp_q.size(), 0);

      // Reset in the middle of a download RAM access
      lat = 10;
      d0 = done_count;
      ioctl_download = 1'b1;
      strobe(25'h0000400, 8'h99);
      wait_until("dl_access_active", 3, 20);
      reset = 1'b1;
      ioctl_download = 1'b0;
      @(negedge clk_sys);
      check("midrst_mem_req", mem_req, 1'b0);
      check("midrst_ioctl_wait", ioctl_wait, 1'b0);
      check("midrst_dl_busy", dl_busy, 1'b0);
      check("midrst_dl_ovf", dl_ovf, 1'b0);
      reset = 1'b0;
      seen = 0;
      repeat (20) begin
         @(negedge clk_sys);
         if (mem_req === 1'b1) seen++;
      end
      check("midrst_fifo_empty", seen, 0);
      check("midrst_no_done", done_count - d0, 0);

      check("scoreboard_drained", exp_q.size(), 0);
      check("cpu_scoreboard_drained", cpu_exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
